// File: rtl/rule_110_run_ctrl.sv
// Run sequencer for a rule-110 engine: loads a seed, steps N generations (or until a
// fixed point), then holds the captured row on a valid/ready result port.
module rule_110_run_ctrl #(
    parameter int unsigned LEN            = 512,
    parameter int unsigned GW             = 16,
    parameter bit          STOP_ON_STABLE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [LEN-1:0] cmd_seed,
    input  logic [GW-1:0]  cmd_gens,
    input  logic           abort,
    output logic           eng_load,
    output logic [LEN-1:0] eng_data,
    input  logic [LEN-1:0] eng_q,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [LEN-1:0] res_row,
    output logic [GW-1:0]  res_gens_run,
    output logic           res_stable,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [LEN-1:0] seed_q, seed_d;
    logic [GW-1:0]  gens_q, gens_d;
    logic [GW-1:0]  cnt_q, cnt_d;
    logic [LEN-1:0] prev_q, prev_d;
    logic [LEN-1:0] row_q, row_d;
    logic [GW-1:0]  gens_run_q, gens_run_d;
    logic           stable_q, stable_d;
    logic           same_row;

    // Generation 0 has no predecessor, so it can never count as a fixed point.
    assign same_row = (cnt_q != '0) && (eng_q == prev_q);

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        gens_d     = gens_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        row_d      = row_q;
        gens_run_d = gens_run_q;
        stable_d   = stable_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    seed_d  = cmd_seed;
                    gens_d  = cmd_gens;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if ((cnt_q == gens_q) || (STOP_ON_STABLE && same_row)) begin
                    row_d      = eng_q;
                    gens_run_d = cnt_q;
                    stable_d   = same_row;
                    state_d    = DONE;
                end else begin
                    prev_d = eng_q;
                    cnt_d  = cnt_q + GW'(1);
                end
            end
            default: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            gens_q     <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            row_q      <= '0;
            gens_run_q <= '0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            gens_q     <= gens_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            row_q      <= row_d;
            gens_run_q <= gens_run_d;
            stable_q   <= stable_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign eng_load     = (state_q == LOAD);
    assign eng_data     = seed_q;
    assign res_valid    = (state_q == DONE);
    assign res_row      = row_q;
    assign res_gens_run = gens_run_q;
    assign res_stable   = stable_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rule_110_run_ctrl.sv
// Bench for rule_110_run_ctrl with a behavioural rule-110 engine (zero boundaries) and a
// scoreboard of expected {row, gens_run, stable, latency} results.
module tb_rule_110_run_ctrl;

    localparam int LEN = 8;
    localparam int GW  = 8;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] gens;
        logic       stable;
        logic [7:0] lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [LEN-1:0] cmd_seed;
    logic [GW-1:0]  cmd_gens;
    logic           abort;
    logic           eng_load;
    logic [LEN-1:0] eng_data;
    logic [LEN-1:0] eng_q = '0;
    logic           res_valid;
    logic           res_ready;
    logic [LEN-1:0] res_row;
    logic [GW-1:0]  res_gens_run;
    logic           res_stable;
    logic           busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Engine: bit i sees left = q[i+1], right = q[i-1]; rule 110 = (c ^ r) | (c & ~l).
    always @(posedge clk) begin
        if (eng_load) eng_q <= eng_data;
        else          eng_q <= (eng_q ^ {eng_q[6:0], 1'b0}) | (eng_q & ~{1'b0, eng_q[7:1]});
    end

    rule_110_run_ctrl #(.LEN(LEN), .GW(GW), .STOP_ON_STABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed), .cmd_gens(cmd_gens),
        .abort(abort),
        .eng_load(eng_load), .eng_data(eng_data), .eng_q(eng_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_gens_run(res_gens_run), .res_stable(res_stable), .busy(busy)
    );

    function automatic logic [7:0] ref_step(input logic [7:0] r);
        logic [9:0] p;
        logic [7:0] rule;
        logic [7:0] o;
        logic [2:0] idx;
        rule = 8'd110;
        p = {1'b0, r, 1'b0};
        for (int i = 0; i < 8; i++) begin
            idx  = {p[i+2], p[i+1], p[i]};
            o[i] = rule[idx];
        end
        return o;
    endfunction

    function automatic exp_t ref_run(input logic [7:0] seed, input logic [7:0] gens);
        exp_t e;
        logic [7:0] row;
        logic [7:0] nxt;
        int k;
        row = seed;
        k = 0;
        e.stable = 1'b0;
        while (k < int'(gens) && !e.stable) begin
            nxt = ref_step(row);
            k++;
            if (nxt == row) e.stable = 1'b1;
            row = nxt;
        end
        e.row  = row;
        e.gens = 8'(k);
        e.lat  = 8'(k + 2);
        return e;
    endfunction

    // Drives one command; returns just after the accept edge with inputs scrambled.
    task automatic send_cmd(input logic [7:0] seed, input logic [7:0] gens);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_seed  = seed;
        cmd_gens  = gens;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_seed  = ~seed;
        cmd_gens  = 8'hFF;
    endtask

    // Counts posedges since accept until res_valid is seen; 300 means it never came.
    task automatic wait_result(input int start, output int edges);
        edges = start;
        while (edges < 300) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (res_valid) break;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({eng_load, res_valid, busy, res_stable} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got load/valid/busy/stable=%b want 0000", {eng_load, res_valid, busy, res_stable});
        end
        checks++;
        if ({res_row, res_gens_run} !== 16'h0000) begin
            errors++; $display("FAIL reset_fields: got row=%h gens=%0d want 0/0", res_row, res_gens_run);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   edges;
        sb.push_back('{row: 8'h0D, gens: 8'd3, stable: 1'b0, lat: 8'd5});
        send_cmd(8'h01, 8'd3);
        @(negedge clk);
        checks++;
        if ({eng_load, busy, eng_data} !== {2'b11, 8'h01}) begin
            errors++; $display("FAIL load_phase: got load=%b busy=%b data=%h want 1 1 01", eng_load, busy, eng_data);
        end
        wait_result(0, edges);
        e = sb.pop_front();
        checks++;
        if ({res_row, res_gens_run, res_stable, 8'(edges)} !== e) begin
            errors++; $display("FAIL basic_result: got row=%h gens=%0d stable=%b lat=%0d want row=%h gens=%0d stable=%b lat=%0d",
                               res_row, res_gens_run, res_stable, edges, e.row, e.gens, e.stable, e.lat);
        end
        release_result();
    endtask

    task automatic test_stable();
        exp_t e;
        int   edges;
        sb.push_back('{row: 8'h00, gens: 8'd1, stable: 1'b1, lat: 8'd3});
        send_cmd(8'h00, 8'd10);
        wait_result(0, edges);
        e = sb.pop_front();
        checks++;
        if ({res_row, res_gens_run, res_stable, 8'(edges)} !== e) begin
            errors++; $display("FAIL stable_result: got row=%h gens=%0d stable=%b lat=%0d want row=%h gens=%0d stable=%b lat=%0d",
                               res_row, res_gens_run, res_stable, edges, e.row, e.gens, e.stable, e.lat);
        end
        release_result();
    endtask

    task automatic test_hold();
        exp_t e;
        int   edges;
        int   bad;
        sb.push_back('{row: 8'h5A, gens: 8'd0, stable: 1'b0, lat: 8'd2});
        send_cmd(8'h5A, 8'd0);
        wait_result(0, edges);
        e = sb.pop_front();
        checks++;
        if ({res_row, res_gens_run, res_stable, 8'(edges)} !== e) begin
            errors++; $display("FAIL zero_gens_result: got row=%h gens=%0d stable=%b lat=%0d want row=%h gens=%0d stable=%b lat=%0d",
                               res_row, res_gens_run, res_stable, edges, e.row, e.gens, e.stable, e.lat);
        end
        bad = 0;
        abort = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ({res_valid, cmd_ready, res_row, res_gens_run, res_stable} !== {2'b10, e.row, e.gens, e.stable}) bad++;
        end
        abort = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_stable: got %0d bad cycles (valid=%b ready=%b row=%h) want 0", bad, res_valid, cmd_ready, res_row);
        end
        release_result();
        checks++;
        if ({res_valid, cmd_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL hold_release: got valid/ready/busy=%b want 010", {res_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   edges;
        int   seen;
        send_cmd(8'h01, 8'd20);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if ({busy, res_valid} !== 2'b10) begin
            errors++; $display("FAIL abort_pre: got busy/valid=%b want 10", {busy, res_valid});
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, res_valid, cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL abort_idle: got busy/valid/ready=%b want 001", {busy, res_valid, cmd_ready});
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
        end
        sb.push_back('{row: 8'h0D, gens: 8'd2, stable: 1'b0, lat: 8'd4});
        send_cmd(8'h03, 8'd2);
        wait_result(0, edges);
        e = sb.pop_front();
        checks++;
        if ({res_row, res_gens_run, res_stable, 8'(edges)} !== e) begin
            errors++; $display("FAIL after_abort_result: got row=%h gens=%0d stable=%b lat=%0d want row=%h gens=%0d stable=%b lat=%0d",
                               res_row, res_gens_run, res_stable, edges, e.row, e.gens, e.stable, e.lat);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        send_cmd(8'h01, 8'd20);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({eng_load, res_valid, busy, res_stable, res_row, res_gens_run} !== 20'h0) begin
            errors++; $display("FAIL midrun_reset: got load=%b valid=%b busy=%b stable=%b row=%h gens=%0d want all 0",
                               eng_load, res_valid, busy, res_stable, res_row, res_gens_run);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, res_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL midrun_release: got ready/valid/busy=%b want 100", {cmd_ready, res_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edges;
        logic [7:0] seed;
        logic [7:0] gens;
        for (int n = 0; n < 10; n++) begin
            seed = 8'($urandom);
            gens = 8'($urandom_range(0, 12));
            sb.push_back(ref_run(seed, gens));
            send_cmd(seed, gens);
            wait_result(0, edges);
            e = sb.pop_front();
            checks++;
            if ({res_row, res_gens_run, res_stable, 8'(edges)} !== e) begin
                errors++; $display("FAIL b2b_result[%0d] seed=%h: got row=%h gens=%0d stable=%b lat=%0d want row=%h gens=%0d stable=%b lat=%0d",
                                   n, seed, res_row, res_gens_run, res_stable, edges, e.row, e.gens, e.stable, e.lat);
            end
            release_result();
        end
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_seed  = '0;
        cmd_gens  = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stable();
        test_hold();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
